// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared state encoding and default widths for the MAC sequencer
// Purpose : state enum and default parameter values used by mac_sequencer and its interface.
// Ports   : none (package).
package mac_seq_pkg;

  localparam int DEF_NUM_WIDTH = 8;
  localparam int DEF_ACC_WIDTH = 2 * DEF_NUM_WIDTH + 1;
  localparam int DEF_CNT_WIDTH = 8;
  localparam int DEF_DRAIN_CYC = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACCUM  = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESULT = 3'd4
  } state_e;

endpackage

// File: rtl/mac_sequencer_if.sv
// rtl/mac_sequencer_if.sv - job, operand, MAC and result signals of the MAC sequencer
// Purpose : bundles the job request, operand stream, MAC drive/return and result port.
// Modports: master - job/operand source, result consumer and MAC datapath side
//           slave  - mac_sequencer side
interface mac_sequencer_if #(
  parameter int NUM_WIDTH = mac_seq_pkg::DEF_NUM_WIDTH,
  parameter int ACC_WIDTH = mac_seq_pkg::DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = mac_seq_pkg::DEF_CNT_WIDTH
);
  logic                 start;
  logic [CNT_WIDTH-1:0] len;
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_WIDTH-1:0] in_a;
  logic [NUM_WIDTH-1:0] in_b;
  logic                 mac_enable;
  logic                 mac_clr;
  logic [NUM_WIDTH-1:0] mac_a;
  logic [NUM_WIDTH-1:0] mac_b;
  logic [ACC_WIDTH-1:0] mac_result;
  logic                 res_valid;
  logic                 res_ready;
  logic [ACC_WIDTH-1:0] res_data;
  logic                 busy;

  modport master (
    output start, len, in_valid, in_a, in_b, mac_result, res_ready,
    input  in_ready, mac_enable, mac_clr, mac_a, mac_b, res_valid, res_data, busy
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, mac_result, res_ready,
    output in_ready, mac_enable, mac_clr, mac_a, mac_b, res_valid, res_data, busy
  );
endinterface

// File: rtl/mac_seq_elem_cnt.sv
// rtl/mac_seq_elem_cnt.sv - clearable up-counter with terminal-count flag
// Purpose : counts enabled cycles; o_tc flags cnt == i_len-1. Used for elements and drain cycles.
// Ports   : clk, rst (async, active-high); i_clr (sync clear, wins over i_en); i_en (increment);
//           i_len (terminal length); o_tc (terminal count reached).
module mac_seq_elem_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_len,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + W'(1);
  end

  assign o_tc = (r_cnt == (i_len - W'(1)));

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - sequences an external MAC datapath through one dot-product job
// Purpose : CLEAR the accumulator, stream LEN operand pairs, drain the MAC pipeline with
//           zero operands, then hold the sum on a valid/ready result port.
// Ports   : clk, reset (async, active-high); bus (mac_sequencer_if.slave).
//           With MAC_SEQ_PERF_EN defined: stall_cnt (ACCUM cycles without in_valid, saturating)
//           and job_cnt (accepted results, wrapping), both 16 bits.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int NUM_WIDTH = DEF_NUM_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
  input  logic          clk,
  input  logic          reset,
  mac_sequencer_if.slave bus
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   job_cnt
`endif
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_len;
  logic                 r_mac_clr;
  logic [ACC_WIDTH-1:0] r_res_data;

  logic                 w_in_ready;
  logic                 w_mac_enable;
  logic [NUM_WIDTH-1:0] w_mac_a;
  logic [NUM_WIDTH-1:0] w_mac_b;
  logic                 w_hs;
  logic                 w_elem_tc;
  logic                 w_drain_tc;
  logic                 w_job_start;

  assign w_hs        = (r_state == S_ACCUM) && bus.in_valid;
  assign w_job_start = (r_state == S_IDLE) && bus.start;

  mac_seq_elem_cnt #(.W(CNT_WIDTH)) u_elem_cnt (
    .clk   (clk),
    .rst   (reset),
    .i_clr ((r_state != S_ACCUM) || (w_hs && w_elem_tc)),
    .i_en  (w_hs),
    .i_len (r_len),
    .o_tc  (w_elem_tc)
  );

  mac_seq_elem_cnt #(.W(CNT_WIDTH)) u_drain_cnt (
    .clk   (clk),
    .rst   (reset),
    .i_clr (r_state != S_DRAIN),
    .i_en  (r_state == S_DRAIN),
    .i_len (CNT_WIDTH'(DRAIN_CYC)),
    .o_tc  (w_drain_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_mac_enable = 1'b0;
    w_mac_a      = '0;
    w_mac_b      = '0;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_nxt = S_CLEAR;
      S_CLEAR:  w_state_nxt = (r_len == '0) ? S_RESULT : S_ACCUM;
      S_ACCUM: begin
        w_in_ready   = 1'b1;
        // Enable only on a handshake so the MAC pipeline freezes during stalls.
        w_mac_enable = bus.in_valid;
        w_mac_a      = bus.in_a;
        w_mac_b      = bus.in_b;
        if (bus.in_valid && w_elem_tc) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Zero operands push the last products through to the accumulator.
        w_mac_enable = 1'b1;
        if (w_drain_tc) w_state_nxt = S_RESULT;
      end
      S_RESULT: if (bus.res_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // mac_clr drives the MAC reset pin, so it comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len      <= '0;
      r_mac_clr  <= 1'b0;
      r_res_data <= '0;
    end else begin
      r_mac_clr <= (w_state_nxt == S_CLEAR);
      if (w_job_start) r_len <= bus.len;
      if (r_state == S_CLEAR && r_len == '0)
        r_res_data <= '0;
      else if (r_state == S_DRAIN && w_drain_tc)
        r_res_data <= bus.mac_result;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.mac_enable = w_mac_enable;
  assign bus.mac_clr    = r_mac_clr;
  assign bus.mac_a      = w_mac_a;
  assign bus.mac_b      = w_mac_b;
  assign bus.res_valid  = (r_state == S_RESULT);
  assign bus.res_data   = r_res_data;
  assign bus.busy       = (r_state != S_IDLE);

`ifdef MAC_SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      job_cnt   <= '0;
    end else begin
      if (w_job_start)
        stall_cnt <= '0;
      else if (r_state == S_ACCUM && !bus.in_valid && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (r_state == S_RESULT && bus.res_ready)
        job_cnt <= job_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - scoreboard bench for mac_sequencer with a 3-stage MAC model
module tb_mac_sequencer;
  import mac_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_sequencer_if #(.NUM_WIDTH(8), .ACC_WIDTH(17), .CNT_WIDTH(8)) bus_if ();

`ifdef MAC_SEQ_PERF_EN
  logic [15:0] stall_cnt, job_cnt;
  mac_sequencer dut (.clk(clk), .reset(rst), .bus(bus_if.slave),
                     .stall_cnt(stall_cnt), .job_cnt(job_cnt));
`else
  mac_sequencer dut (.clk(clk), .reset(rst), .bus(bus_if.slave));
`endif

  // MAC datapath model: operand regs -> product -> accumulator, frozen when not enabled.
  logic [7:0]  m_a = '0, m_b = '0;
  logic [15:0] m_p = '0;
  logic [16:0] m_acc = '0;
  always @(posedge clk) begin
    if (bus_if.mac_clr) begin
      m_a <= '0; m_b <= '0; m_p <= '0; m_acc <= '0;
    end else if (bus_if.mac_enable) begin
      m_a   <= bus_if.mac_a;
      m_b   <= bus_if.mac_b;
      m_p   <= m_a * m_b;
      m_acc <= m_acc + 17'(m_p);
    end
  end
  assign bus_if.mac_result = m_acc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0, clr_cnt = 0, rdy_cnt = 0, en_bad = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  ta[256];
  logic [7:0]  tb[256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard monitor and activity counters.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.mac_enable) en_cnt++;
      if (bus_if.mac_clr) clr_cnt++;
      if (bus_if.in_ready) rdy_cnt++;
      if (bus_if.in_ready && !bus_if.in_valid && bus_if.mac_enable) en_bad++;
      if (bus_if.res_valid && bus_if.res_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_result", 1, 0);
        else chk("sb_res_data", 32'(bus_if.res_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic clear_stats();
    en_cnt = 0; clr_cnt = 0; rdy_cnt = 0; en_bad = 0;
  endtask

  task automatic run_job(input int n, input int gap_at, input int gap_len,
                         input logic [16:0] expv, input string nm, output int hs_cyc);
    int i, g, t, c_start, first_rdy;
    hs_cyc = 0;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    bus_if.start = 1'b1; bus_if.len = 8'(n);
    @(negedge clk); c_start = cyc;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    i = 0; g = 0; t = 0; first_rdy = -1;
    while (i < n && t < 2000) begin
      if (i == gap_at && g < gap_len) begin
        bus_if.in_valid = 1'b0; g++;
      end else begin
        bus_if.in_valid = 1'b1; bus_if.in_a = ta[i]; bus_if.in_b = tb[i];
      end
      @(negedge clk);
      if (bus_if.in_ready && first_rdy < 0) first_rdy = cyc;
      if (bus_if.in_valid && bus_if.in_ready) begin i++; hs_cyc = cyc; end
      @(posedge clk); #1;
      t++;
    end
    bus_if.in_valid = 1'b0;
    if (t >= 2000) chk({nm, "_feed_timeout"}, 1, 0);
    if (n > 0) chk({nm, "_start_to_ready"}, 32'(first_rdy - c_start), 2);
  endtask

  task automatic wait_result(input int hs_cyc, input bit chk_lat, input int hold, input string nm);
    int t;
    logic [16:0] d;
    t = 0;
    @(negedge clk);
    while (!bus_if.res_valid && t < 100) begin @(negedge clk); t++; end
    chk({nm, "_res_valid"}, 32'(bus_if.res_valid), 1);
    if (chk_lat) chk({nm, "_latency"}, 32'(cyc - hs_cyc), 4);
    d = bus_if.res_data;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      bus_if.start = (k == 3);
      bus_if.len = 8'd5;
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(bus_if.res_valid), 1);
      chk({nm, "_hold_data"}, 32'(bus_if.res_data), 32'(d));
    end
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.res_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.res_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_after_accept"}, 32'(bus_if.busy), 0);
    chk({nm, "_valid_dropped"}, 32'(bus_if.res_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int hs, n;
    bus_if.start = 0; bus_if.len = 0; bus_if.in_valid = 0;
    bus_if.in_a = 0; bus_if.in_b = 0; bus_if.res_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus_if.in_ready), 0);
    chk("rst_mac_enable", 32'(bus_if.mac_enable), 0);
    chk("rst_mac_clr", 32'(bus_if.mac_clr), 0);
    chk("rst_res_valid", 32'(bus_if.res_valid), 0);
    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_res_data", 32'(bus_if.res_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: 1*5+2*6+3*7+4*8 = 70, in_valid held high
    for (int i = 0; i < 4; i++) begin ta[i] = 8'(i + 1); tb[i] = 8'(i + 5); end
    clear_stats();
    run_job(4, -1, 0, 17'd70, "t1", hs);
    wait_result(hs, 1'b1, 0, "t1");
    chk("t1_clr_pulses", 32'(clr_cnt), 1);
    chk("t1_enable_cycles", 32'(en_cnt), 7);

    // 2: same job, 3 idle cycles before element 3
    clear_stats();
    run_job(4, 2, 3, 17'd70, "t2", hs);
    wait_result(hs, 1'b1, 0, "t2");
    chk("t2_enable_cycles", 32'(en_cnt), 7);
    chk("t2_enable_in_gap", 32'(en_bad), 0);
`ifdef MAC_SEQ_PERF_EN
    chk("t2_stall_cnt", 32'(stall_cnt), 3);
    chk("t2_job_cnt", 32'(job_cnt), 2);
`endif

    // 3: len=0 goes CLEAR -> RESULT with zero
    clear_stats();
    run_job(0, -1, 0, 17'd0, "t3", hs);
    wait_result(hs, 1'b0, 0, "t3");
    chk("t3_enable_cycles", 32'(en_cnt), 0);
    chk("t3_ready_cycles", 32'(rdy_cnt), 0);
    chk("t3_clr_pulses", 32'(clr_cnt), 1);

    // 4: 255 * 255*255 = 16581375; mod 2**17 = 66303 = 17'h102FF
    for (int i = 0; i < 255; i++) begin ta[i] = 8'hFF; tb[i] = 8'hFF; end
    clear_stats();
    run_job(255, -1, 0, 17'h102FF, "t4", hs);
    wait_result(hs, 1'b1, 0, "t4");
    chk("t4_enable_cycles", 32'(en_cnt), 258);

    // 5: 10*3+20*4 = 110, result held 10 cycles with a start pulse in between
    ta[0] = 8'd10; ta[1] = 8'd20; tb[0] = 8'd3; tb[1] = 8'd4;
    run_job(2, -1, 0, 17'd110, "t5", hs);
    wait_result(hs, 1'b1, 10, "t5");
    repeat (3) @(negedge clk);
    chk("t5_start_ignored", 32'(bus_if.busy), 0);

    // 6: reset while element 3 of 4 is pending, then len=2 job 3*2+3*2 = 12
    for (int i = 0; i < 4; i++) begin ta[i] = 8'(i + 1); tb[i] = 8'(i + 5); end
    @(posedge clk); #1;
    bus_if.start = 1'b1; bus_if.len = 8'd4;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    n = 0;
    for (int t = 0; t < 50 && n < 2; t++) begin
      bus_if.in_valid = 1'b1; bus_if.in_a = ta[n]; bus_if.in_b = tb[n];
      @(negedge clk);
      if (bus_if.in_ready) n++;
      @(posedge clk); #2;
    end
    bus_if.in_a = ta[2]; bus_if.in_b = tb[2];
    #1;
    chk("t6_pre_reset_ready", 32'(bus_if.in_ready), 1);
    rst = 1'b1;
    #1;
    chk("t6_async_in_ready", 32'(bus_if.in_ready), 0);
    chk("t6_async_mac_enable", 32'(bus_if.mac_enable), 0);
    chk("t6_async_mac_a", 32'(bus_if.mac_a), 0);
    chk("t6_async_mac_b", 32'(bus_if.mac_b), 0);
    chk("t6_async_busy", 32'(bus_if.busy), 0);
    chk("t6_async_res_valid", 32'(bus_if.res_valid), 0);
    chk("t6_async_mac_clr", 32'(bus_if.mac_clr), 0);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ta[0] = 8'd3; ta[1] = 8'd3; tb[0] = 8'd2; tb[1] = 8'd2;
    clear_stats();
    run_job(2, -1, 0, 17'd12, "t6", hs);
    wait_result(hs, 1'b1, 0, "t6");
    chk("t6_clr_pulses", 32'(clr_cnt), 1);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
